dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
Two-port arbiter sharing the single-port Data_Memory between the CPU load/store path and an I/O/DMA requester. Each requester uses a req/ack handshake. The arbiter latches the winner's command and drives dm_cs/dm_rd/dm_wr for exactly one cycle, then returns read data with a one-cycle ack pulse. It sits between the Control_Unit/Integer_Datapath memory path and the Data_Memory instance in the top level.

Parameters:
ADDR_W, 12, byte address width; matches Data_Memory Addr.
DATA_W, 32, word width.
RR_EN, 1, selects the priority scheme: 1 = round-robin, 0 = fixed priority (cpu always wins).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU access request; held high until cpu_ack.
cpu_wr  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  CPU byte address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_ack  out  1  one-cycle completion pulse.
cpu_err  out  1  valid with cpu_ack; misaligned address.
cpu_rdata  out  DATA_W  CPU read data; registered.
io_req, io_wr, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  I/O requester; same meaning as the cpu_* inputs.
io_ack, io_err, io_rdata  out  1/1/DATA_W  I/O responses; same meaning as the cpu_* outputs.
dm_cs  out  1  memory chip select.
dm_rd  out  1  memory read enable.
dm_wr  out  1  memory write enable.
dm_addr  out  ADDR_W  memory address.
dm_din  out  DATA_W  write data to memory D_in.
dm_dout  in  DATA_W  read data from memory D_out (combinational while cs&rd).
busy  out  1  high in any state other than IDLE.
gnt_id  out  1  owner of the current transaction: 0 = cpu, 1 = io.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; all outputs 0.
  - rdata registers = 0.
  - last-grant pointer = 1, so cpu wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Only the IDLE state samples requests.
- IDLE:
  - On a rising edge with any req high, select a winner.
  - With RR_EN = 1, the winner is the requester not equal to the last-grant pointer when both request; otherwise the sole requester.
  - With RR_EN = 0, cpu always wins when both request.
  - Latch wr, addr and wdata into command registers; set gnt_id and update the pointer; go to ACCESS.
- ACCESS (one cycle):
  - If addr[1:0] == 0: dm_cs = 1; dm_rd = ~wr; dm_wr = wr; dm_addr and dm_din come from the latched registers.
  - If addr[1:0] != 0: all dm strobes stay 0 and the err flag is latched.
  - At the edge ending ACCESS, on a read, dm_dout is captured into the winner's rdata register.
  - The memory write commits at that same edge.
- RESP (one cycle):
  - The winner's ack = 1; its err = latched flag.
  - On a write or an error, rdata is unchanged.
  - Next state is always IDLE; req is ignored during RESP.
- Latency and throughput:
  - Latency: req sampled at edge N, ACCESS in cycle N+1, ack in cycle N+2.
  - Minimum spacing between grants is 3 cycles.
- Requester rules:
  - The requester drops req in the cycle ack is seen.
  - If req is still high in IDLE, it is treated as a new request.
- Outputs:
  - The loser's request stays pending with no ack.
  - rdata holds its value until that requester's next read completes.
  - dm_* outputs are registered or purely state-decoded, glitch-free; dm_addr and dm_din are 0 outside ACCESS.
- Reset mid-ACCESS: strobes drop immediately; no ack is issued. Write commit is undefined only if rst coincides with the ending edge.
- Changes to command inputs after the IDLE sample have no effect; the latched values are used.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined:
  - Adds outputs cpu_gnt_cnt[15:0], io_gnt_cnt[15:0] and conflict_cnt[15:0].
  - The grant counters increment on each RESP of the respective requester.
  - conflict_cnt increments when both reqs are high at an IDLE sample.
  - All counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - requester IDs: REQ_CPU = 1'b0, REQ_IO = 1'b1;
  - ADDR_W and DATA_W defaults.
- Natural sub-module: dm_arb_pick, a combinational 2-way round-robin/fixed-priority picker taking req[1:0], the last-grant pointer and RR_EN, producing grant and conflict.

Test Plan:
1. CPU write, then read, at addr 12'h010 with data 32'hDEADBEEF:
   - dm_wr high for exactly 1 cycle; cpu_ack 2 cycles after the sample.
   - The read returns cpu_rdata = 32'hDEADBEEF with cpu_err = 0.
2. Simultaneous cpu/io reads, RR_EN = 1, after reset:
   - cpu is granted first (gnt_id = 0), then io; io_ack arrives 3 cycles after cpu_ack.
   - Repeated simultaneous requests alternate 0, 1, 0, 1.
3. Same as scenario 2 with RR_EN = 0 and cpu_req held continuously high:
   - io is never granted while cpu_req is high.
   - io is granted in the first IDLE after cpu_req drops.
4. io read at addr 12'h013 (misaligned):
   - No dm_cs pulse; io_ack = 1 with io_err = 1; io_rdata unchanged.
5. Assert rst during ACCESS of a cpu write:
   - dm_cs/dm_wr drop asynchronously; no cpu_ack; busy = 0.
   - After release, a new request completes normally.
6. DM_ARB_STATS_EN defined, 3 conflicting request pairs:
   - cpu_gnt_cnt = 3, io_gnt_cnt = 3, conflict_cnt ≥ 3.
   - Preload a counter to 16'hFFFF via force: it stays at FFFF.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the Data_Memory arbiter: FSM state encoding,
// requester IDs, default bus widths and the saturating counter helper.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational 2-way picker. req[0] is the CPU, req[1] is the I/O port.
// On a tie, round-robin gives the grant to whoever did not win last time;
// fixed priority always hands it to the CPU.
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       grant,
    output logic       conflict
);

    // Winner selection; grant is a don't-care when nobody requests.
    always_comb begin
        conflict = req[0] & req[1];
        grant    = REQ_CPU;
        if (conflict) begin
            grant = RR_EN ? ~last_gnt : REQ_CPU;
        end else if (req[1]) begin
            grant = REQ_IO;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port Data_Memory.
// One transaction at a time: IDLE samples requests, ACCESS drives the memory
// strobes for a single cycle, RESP pulses the winner's ack.
// Optional statistics counters are built when DM_ARB_STATS_EN is defined.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic              io_err,
    output logic [DATA_W-1:0] io_rdata,
    output logic              dm_cs,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              busy,
    output logic              gnt_id
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       io_gnt_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    state_t              state_reg;
    state_t              state_next;
    logic                cmd_wr_reg;
    logic [ADDR_W-1:0]   cmd_addr_reg;
    logic [DATA_W-1:0]   cmd_wdata_reg;
    logic                gnt_id_reg;
    logic                last_gnt_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   cpu_rdata_reg;
    logic [DATA_W-1:0]   io_rdata_reg;

    logic [1:0]          req_vec;
    logic                any_req;
    logic                pick_grant;
    logic                pick_conflict;
    logic                in_idle;
    logic                in_access;
    logic                in_resp;
    logic                aligned;

    assign req_vec   = {io_req, cpu_req};
    assign any_req   = |req_vec;
    assign in_idle   = (state_reg == IDLE);
    assign in_access = (state_reg == ACCESS);
    assign in_resp   = (state_reg == RESP);
    assign aligned   = (cmd_addr_reg[1:0] == 2'b00);

    dm_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req      (req_vec),
        .last_gnt (last_gnt_reg),
        .grant    (pick_grant),
        .conflict (pick_conflict)
    );

    // State register; reset drops any access in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fixed three-step sequence; only IDLE looks at the requests.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's command at the IDLE sample; flag misalignment in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            gnt_id_reg    <= REQ_CPU;
            last_gnt_reg  <= REQ_IO;
            err_reg       <= 1'b0;
        end else begin
            if (in_idle && any_req) begin
                cmd_wr_reg    <= (pick_grant == REQ_IO) ? io_wr    : cpu_wr;
                cmd_addr_reg  <= (pick_grant == REQ_IO) ? io_addr  : cpu_addr;
                cmd_wdata_reg <= (pick_grant == REQ_IO) ? io_wdata : cpu_wdata;
                gnt_id_reg    <= pick_grant;
                last_gnt_reg  <= pick_grant;
            end
            if (in_access) begin
                err_reg <= ~aligned;
            end
        end
    end

    // Capture memory read data into the owner's register at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_reg <= '0;
            io_rdata_reg  <= '0;
        end else if (in_access && aligned && !cmd_wr_reg) begin
            if (gnt_id_reg == REQ_IO) begin
                io_rdata_reg <= dm_dout;
            end else begin
                cpu_rdata_reg <= dm_dout;
            end
        end
    end

    // Memory strobes are pure decodes of registered state, one cycle wide.
    assign dm_cs   = in_access & aligned;
    assign dm_rd   = dm_cs & ~cmd_wr_reg;
    assign dm_wr   = dm_cs & cmd_wr_reg;
    assign dm_addr = in_access ? cmd_addr_reg  : '0;
    assign dm_din  = in_access ? cmd_wdata_reg : '0;

    assign cpu_ack   = in_resp & (gnt_id_reg == REQ_CPU);
    assign io_ack    = in_resp & (gnt_id_reg == REQ_IO);
    assign cpu_err   = cpu_ack & err_reg;
    assign io_err    = io_ack & err_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign io_rdata  = io_rdata_reg;
    assign busy      = ~in_idle;
    assign gnt_id    = gnt_id_reg;

`ifdef DM_ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt_reg;
    logic [15:0] io_gnt_cnt_reg;
    logic [15:0] conflict_cnt_reg;

    // Saturating grant and contention counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_gnt_cnt_reg  <= '0;
            io_gnt_cnt_reg   <= '0;
            conflict_cnt_reg <= '0;
        end else begin
            if (in_resp && gnt_id_reg == REQ_CPU) begin
                cpu_gnt_cnt_reg <= sat_inc(cpu_gnt_cnt_reg);
            end
            if (in_resp && gnt_id_reg == REQ_IO) begin
                io_gnt_cnt_reg <= sat_inc(io_gnt_cnt_reg);
            end
            if (in_idle && pick_conflict) begin
                conflict_cnt_reg <= sat_inc(conflict_cnt_reg);
            end
        end
    end

    assign cpu_gnt_cnt  = cpu_gnt_cnt_reg;
    assign io_gnt_cnt   = io_gnt_cnt_reg;
    assign conflict_cnt = conflict_cnt_reg;
`else
    // Contention is only counted in the statistics build.
    logic unused_conflict;
    assign unused_conflict = pick_conflict;
`endif

endmodule
